// File: rtl/csidh_key_sampler_if.sv
// Entropy nibble stream between the random source (master) and the key sampler (slave).
interface csidh_key_sampler_if #(
  parameter int unsigned E_W = 4
) ();
  logic           rnd_valid;
  logic [E_W-1:0] rnd_data;
  logic           rnd_ready;

  modport master (output rnd_valid, output rnd_data, input rnd_ready);
  modport slave  (input rnd_valid, input rnd_data, output rnd_ready);
endinterface

// File: rtl/csidh_key_sampler.sv
// CSIDH private-exponent sampler: rejection-samples one exponent in [-MAX_E, MAX_E] per prime.
// Optional macro KEY_SAMPLER_REJECT_CNT_EN adds a saturating 16-bit rejected-beat counter.
module csidh_key_sampler #(
  parameter int unsigned NUM_PRIMES = 74,
  parameter int unsigned E_W        = 4,
  parameter int unsigned MAX_E      = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  csidh_key_sampler_if.slave         rnd,
  output logic [NUM_PRIMES*E_W-1:0]  private_o,
  output logic                       key_valid_o,
  output logic                       busy_o,
`ifdef KEY_SAMPLER_REJECT_CNT_EN
  output logic [15:0]                reject_cnt_o,
`endif
  output logic                       done_o
);

  localparam int unsigned     IdxW    = (NUM_PRIMES > 1) ? $clog2(NUM_PRIMES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_PRIMES - 1);
  localparam logic [E_W-1:0]  MaxV    = E_W'(2 * MAX_E);
  localparam logic [E_W-1:0]  Off     = E_W'(MAX_E);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSample = 2'd1;
  localparam logic [1:0] StLoad   = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [NUM_PRIMES*E_W-1:0] work_q, work_d;
  logic [NUM_PRIMES*E_W-1:0] priv_q, priv_d;
  logic                      kv_q, kv_d;
  logic                      accept, reject;

  assign accept = rnd.rnd_valid && (state_q == StSample);
  assign reject = accept && (rnd.rnd_data > MaxV);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    work_d  = work_q;
    priv_d  = priv_q;
    kv_d    = kv_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StSample;
          idx_d   = '0;
          kv_d    = 1'b0;
        end
      end
      StSample: begin
        if (accept && !reject) begin
          // Offset maps 0..2*MAX_E onto -MAX_E..MAX_E in two's complement.
          work_d[idx_q*E_W +: E_W] = rnd.rnd_data - Off;
          idx_d = idx_q + 1'b1;
          if (idx_q == LastIdx) state_d = StLoad;
        end
      end
      StLoad: begin
        priv_d  = work_q;
        kv_d    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      work_q  <= '0;
      priv_q  <= '0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      priv_q  <= priv_d;
      kv_q    <= kv_d;
    end
  end

`ifdef KEY_SAMPLER_REJECT_CNT_EN
  logic [15:0] rcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q <= '0;
    end else if (state_q == StIdle && start_i) begin
      rcnt_q <= '0;
    end else if (reject && rcnt_q != 16'hFFFF) begin
      rcnt_q <= rcnt_q + 16'd1;
    end
  end

  assign reject_cnt_o = rcnt_q;
`endif

  assign rnd.rnd_ready = (state_q == StSample);
  assign busy_o        = (state_q == StSample);
  assign done_o        = (state_q == StLoad);
  assign private_o     = priv_q;
  assign key_valid_o   = kv_q;

endmodule

// File: doc/csidh_key_sampler.md
Name: csidh_key_sampler

Overview:
- Upstream stage of the CSIDH group-action core. Produces the packed 296-bit private exponent vector that the core consumes on its `private` input.
- Draws 4-bit entropy nibbles over a valid/ready stream and applies rejection sampling to get one exponent in [-MAX_E, +MAX_E] per prime.
- Assembles NUM_PRIMES such exponents, then presents the completed vector with a one-cycle done pulse.

Parameters:
- NUM_PRIMES, 74, number of small primes (exponent fields).
- E_W, 4, bit width of one exponent field and of the entropy nibble.
- MAX_E, 5, exponent bound. Constraints: 2*MAX_E+1 <= 2^E_W and MAX_E <= 2^(E_W-1)-1.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new key; sampled only in IDLE.
- rnd_valid  input  1  entropy nibble valid.
- rnd_data  input  E_W  entropy nibble, uniform over 0..2^E_W-1.
- rnd_ready  output  1  sampler accepts a nibble this cycle.
- private  output  NUM_PRIMES*E_W  packed exponent vector; field i = private[E_W*i+E_W-1 : E_W*i], two's complement.
- key_valid  output  1  private holds a complete key.
- busy  output  1  sampling in progress.
- done  output  1  one-cycle pulse when a new key is loaded.

Behaviour:
- Reset: synchronous, active-high; one clock domain (clk).
  - On rst high at a clock edge: FSM to IDLE, field index cleared, work register cleared.
  - Outputs after reset: private=0, key_valid=0, busy=0, done=0, rnd_ready=0.
  - rst overrides every other input in the same cycle.
- States: IDLE, SAMPLE, LOAD.
- IDLE:
  - rnd_ready=0, busy=0.
  - start=1 -> SAMPLE. Index is set to 0 and key_valid is cleared on the next edge; private keeps its old value.
- SAMPLE:
  - busy=1, rnd_ready=1 combinationally.
  - A beat is accepted when rnd_valid && rnd_ready.
  - Accepted beat with v = rnd_data <= 2*MAX_E: write (v - MAX_E) as E_W-bit two's complement into work field [index], then index++.
  - Accepted beat with v > 2*MAX_E: rejected; no write, index unchanged.
  - Accepted, non-rejected beat when index == NUM_PRIMES-1 -> LOAD.
  - start is ignored while in SAMPLE.
- LOAD (exactly one cycle):
  - private <= work register, key_valid <= 1.
  - done=1 for this single cycle, busy=0, rnd_ready=0. Next state IDLE.
  - A start arriving in LOAD is ignored; start must be reasserted in IDLE.
- Latency: start sampled at cycle 0, rnd_ready high from cycle 1. With continuous valid nibbles and no rejections, beats occupy cycles 1..NUM_PRIMES and done is high at cycle NUM_PRIMES+1 (cycle 75 at defaults). Each rejection or rnd_valid gap adds one cycle.
- Field order: field 0 (LSBs) is prime index 0 (smallest prime), filled first.
- private and key_valid are registered outputs. private changes only in LOAD or on reset.
- Reset mid-operation:
  - Partial key is discarded; no done pulse.
  - private=0 and key_valid=0 after the reset edge.
  - A subsequent start behaves exactly as after power-up.

Optional Feature:
- Macro: KEY_SAMPLER_REJECT_CNT_EN.
- When defined:
  - Adds output reject_cnt, 16 bits: count of rejected beats in the current or last key.
  - Cleared to 0 on reset and on the IDLE->SAMPLE transition.
  - Saturates at 16'hFFFF and holds its value after LOAD.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst 3 cycles with start=1 and rnd_valid=1 -> private=0, key_valid=0, busy=0, rnd_ready=0, done never pulses.
- Zero key: start, then 74 consecutive nibbles 4'h5 -> done at cycle 75, private=296'h0, key_valid=1, exactly one done pulse.
- Extremes: all nibbles 4'hA -> every field 4'h5 (private = 74 hex '5' digits). Repeat with all 4'h0 -> every field 4'hB (-5).
- Rejection: interleave 4'hF, 4'hB and 4'hC before each of 74 nibbles 4'h6 -> 222 rejects, every field 4'h1, done at cycle 297, reject_cnt=222 with macro defined.
- Handshake: toggle rnd_valid 1/0 every cycle and pulse start mid-SAMPLE -> start has no effect, no data lost, done at cycle 148, fields match stimulus order.
- Reset mid-op: assert rst after 30 accepted nibbles -> no done, private=0, key_valid=0. Next start with nibbles 0..10 cycling -> field i = (i mod 11) - 5.
